serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 13 +
 rtl/serial_tx_if.sv | 12 +
 rtl/baud_counter.sv | 41 ++++
 rtl/serial_tx.sv | 117 +++++++++++
 tb/tb_serial_tx.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Definitions shared by the serial transmitter and its matching receiver:
// the frame FSM encoding and the default frame timing.
package serial_pkg;
   localparam int unsigned DEF_CLKS_PER_BIT = 32'd4;
   localparam int unsigned DEF_DATA_BITS    = 32'd8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } serial_state_e;
endpackage

// File: rtl/serial_tx_if.sv
// Parallel-load request side and serial line of the transmitter.
// The transmitter sits on the slave modport; its user drives the master side.
interface serial_tx_if #(parameter int DATA_BITS = serial_pkg::DEF_DATA_BITS);
   logic [DATA_BITS-1:0] DATA;
   logic                 SEND;
   logic                 TX;
   logic                 BUSY;
   logic                 DONE;

   modport master (output DATA, output SEND, input TX, input BUSY, input DONE);
   modport slave  (input DATA, input SEND, output TX, output BUSY, output DONE);
endinterface

// File: rtl/baud_counter.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period with tick; clear pins it at zero so a new frame starts on a boundary.
module baud_counter
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic CLK,
   input  logic RESET_N,
   input  logic clear,
   output logic tick
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: held at zero while cleared, wraps at the bit boundary
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_MAX);
endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_BITS payload bits LSB first, stop bit,
// each held CLKS_PER_BIT cycles. TX, BUSY and DONE come straight from flops.
module serial_tx
   import serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS
) (
   input  logic       CLK,
   input  logic       RESET_N,
   serial_tx_if.slave bus
);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   serial_state_e        state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 tick;
   logic                 baud_clear;

   assign baud_clear = (state_q == ST_IDLE);

   baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .clear   (baud_clear),
      .tick    (tick)
   );

   // State, datapath and output registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state; requests are only looked at while idle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.SEND) state_d = ST_START;
            else          state_d = ST_IDLE;
         end
         ST_START: begin
            if (tick) state_d = ST_DATA;
            else      state_d = ST_START;
         end
         ST_DATA: begin
            if (tick && (idx_q == IDX_LAST)) state_d = ST_STOP;
            else                             state_d = ST_DATA;
         end
         ST_STOP: begin
            if (tick) state_d = ST_IDLE;
            else      state_d = ST_STOP;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift register and bit index; the payload is captured only on acceptance
   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            if (bus.SEND) shift_d = bus.DATA;
            else          shift_d = shift_q;
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
               shift_d = shift_q;
               idx_d   = idx_q;
            end
         end
         default: idx_d = '0;
      endcase
   end

   // Outputs are decoded from the next state so the flops line up with it
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         ST_STOP:  tx_d = 1'b1;
         ST_IDLE:  tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
   end

   assign bus.TX   = tx_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a default 4x8 instance and a 2x5 instance share the clock
// and reset; a per-cycle monitor captures each frame and checks it against a queue.
module tb_serial_tx;
   logic CLK;
   logic rst_n;

   serial_tx_if #(.DATA_BITS(8)) bus_a ();
   serial_tx_if #(.DATA_BITS(5)) bus_b ();

   serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_a (.CLK(CLK), .RESET_N(rst_n), .bus(bus_a));
   serial_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dut_b (.CLK(CLK), .RESET_N(rst_n), .bus(bus_b));

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // line level per bit slot, slot 0 = start bit
   } vec_t;

   vec_t         vecs[6];
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [9:0]   exp_q0[$];
   logic [9:0]   exp_q1[$];
   int           m_cnt[2];
   int           m_gap[2];
   int           m_last_gap[2];
   int           m_done[2];
   logic [127:0] m_cap[2];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon(input int id, input logic tx, input logic busy, input logic done);
      int         cpb;
      int         nbits;
      int         bad;
      logic [9:0] fr;
      logic [9:0] got;
      cpb   = (id == 0) ? 4 : 2;
      nbits = (id == 0) ? 10 : 7;
      if (!rst_n) begin
         m_cnt[id] = 0;
         m_gap[id] = 0;
      end else if (busy) begin
         if (m_cnt[id] == 0) m_last_gap[id] = m_gap[id];
         if (m_cnt[id] < 128) m_cap[id][m_cnt[id]] = tx;
         m_cnt[id]++;
         check($sformatf("dut%0d_done_low_while_busy", id), 32'(done), 32'd0);
      end else if (m_cnt[id] != 0) begin
         check($sformatf("dut%0d_frame_len", id), m_cnt[id], cpb * nbits);
         check($sformatf("dut%0d_done_pulse", id), 32'(done), 32'd1);
         check($sformatf("dut%0d_tx_high_after_stop", id), 32'(tx), 32'd1);
         if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
            check($sformatf("dut%0d_unexpected_frame", id), 32'd1, 32'd0);
         end else begin
            if (id == 0) fr = exp_q0.pop_front();
            else         fr = exp_q1.pop_front();
            bad = 0;
            got = '0;
            for (int i = 0; i < cpb * nbits; i++) begin
               if (m_cap[id][i] !== fr[i / cpb]) bad++;
            end
            for (int b = 0; b < nbits; b++) got[b] = m_cap[id][b * cpb + cpb / 2];
            check($sformatf("dut%0d_frame_bits", id), 32'(got), 32'(fr));
            check($sformatf("dut%0d_bad_cycles", id), bad, 0);
         end
         m_done[id]++;
         m_gap[id] = 1;
         m_cnt[id] = 0;
      end else begin
         check($sformatf("dut%0d_done_idle", id), 32'(done), 32'd0);
         check($sformatf("dut%0d_tx_idle", id), 32'(tx), 32'd1);
         m_gap[id]++;
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
      mon(0, bus_a.TX, bus_a.BUSY, bus_a.DONE);
      mon(1, bus_b.TX, bus_b.BUSY, bus_b.DONE);
   endtask

   task automatic send_a(input logic [7:0] d, input logic [9:0] fr);
      exp_q0.push_back(fr);
      bus_a.DATA = d;
      bus_a.SEND = 1'b1;
      cyc();
      bus_a.SEND = 1'b0;
   endtask

   task automatic wait_done(input int id, input int target, input int budget);
      int k = 0;
      while (m_done[id] < target && k < budget) begin
         cyc();
         k++;
      end
      check($sformatf("dut%0d_frame_complete", id), 32'(m_done[id] >= target), 32'd1);
   endtask

   task automatic wait_cnt(input int id, input int target, input int budget);
      int k = 0;
      while (m_cnt[id] < target && k < budget) begin
         cyc();
         k++;
      end
      check($sformatf("dut%0d_reached_cycle", id), 32'(m_cnt[id] >= target), 32'd1);
   endtask

   initial begin
      int d;
      int k;
      vecs[0] = '{8'hA5, 10'b1101001010};
      vecs[1] = '{8'h5A, 10'b1010110100};
      vecs[2] = '{8'h01, 10'b1000000010};
      vecs[3] = '{8'h80, 10'b1100000000};
      vecs[4] = '{8'hFF, 10'b1111111110};
      vecs[5] = '{8'h00, 10'b1000000000};
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_gap[i] = 0; m_last_gap[i] = 0; m_done[i] = 0; m_cap[i] = '0;
      end
      rst_n      = 1'b1;
      bus_a.DATA = 8'h00;
      bus_a.SEND = 1'b0;
      bus_b.DATA = 5'h00;
      bus_b.SEND = 1'b0;

      // Reset asserted between edges must act before the next edge
      #3 rst_n = 1'b0;
      #1;
      check("reset_tx", 32'(bus_a.TX), 32'd1);
      check("reset_busy", 32'(bus_a.BUSY), 32'd0);
      check("reset_done", 32'(bus_a.DONE), 32'd0);
      check("reset_b_tx", 32'(bus_b.TX), 32'd1);
      cyc();
      cyc();
      #2 rst_n = 1'b1;
      cyc();

      foreach (vecs[i]) begin
         d = m_done[0];
         send_a(vecs[i].data, vecs[i].frame);
         wait_done(0, d + 1, 60);
      end

      // Narrow instance: 5'h11 -> 0,1,0,0,0,1,1 over 14 cycles
      d = m_done[1];
      exp_q1.push_back(10'b0001100010);
      bus_b.DATA = 5'h11;
      bus_b.SEND = 1'b1;
      cyc();
      bus_b.SEND = 1'b0;
      wait_done(1, d + 1, 40);

      // Request during a frame must be dropped
      d = m_done[0];
      send_a(8'h00, 10'b1000000000);
      wait_cnt(0, 9, 20);
      bus_a.DATA = 8'hFF;
      bus_a.SEND = 1'b1;
      cyc();
      bus_a.SEND = 1'b0;
      wait_done(0, d + 1, 60);
      repeat (50) cyc();
      check("ignored_single_done", m_done[0], d + 1);
      check("ignored_queue_empty", exp_q0.size(), 0);

      // SEND held high: two frames with a single idle cycle between them
      d = m_done[0];
      exp_q0.push_back(10'b1001111000);
      exp_q0.push_back(10'b1001111000);
      bus_a.DATA = 8'h3C;
      bus_a.SEND = 1'b1;
      k = 0;
      while (m_done[0] < d + 2 && k < 200) begin
         cyc();
         k++;
      end
      bus_a.SEND = 1'b0;
      check("b2b_done_count", m_done[0], d + 2);
      check("b2b_idle_gap", m_last_gap[0], 1);
      repeat (3) cyc();
      check("b2b_no_third_frame", 32'(bus_a.BUSY), 32'd0);

      // Reset during data bit 3 aborts the frame at once, no DONE
      d = m_done[0];
      send_a(8'hC3, 10'b1110000110);
      wait_cnt(0, 18, 30);
      check("pre_reset_data_bit3", 32'(bus_a.TX), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_tx", 32'(bus_a.TX), 32'd1);
      check("abort_busy", 32'(bus_a.BUSY), 32'd0);
      check("abort_done", 32'(bus_a.DONE), 32'd0);
      exp_q0.delete();
      cyc();
      cyc();
      #2;
      rst_n = 1'b1;
      exp_q0.push_back(10'b1010110100);
      bus_a.DATA = 8'h5A;
      bus_a.SEND = 1'b1;
      cyc();
      bus_a.SEND = 1'b0;
      check("post_reset_busy", 32'(bus_a.BUSY), 32'd1);
      check("post_reset_tx", 32'(bus_a.TX), 32'd0);
      wait_done(0, d + 1, 60);
      repeat (3) cyc();
      check("post_reset_done_count", m_done[0], d + 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
